// File: rtl/booth_seq_arbiter.sv
// Shared sequential radix-2 Booth multiplier fronted by a 2-way round-robin arbiter.
// One Booth step is performed per clock; each result is tagged with the requester ID.
// Optional build macro BOOTH_ZERO_BYPASS_EN: when defined, a request with a zero
// operand skips the Booth steps and its result is presented one cycle after acceptance.
//
// state | meaning
// IDLE  | arbitrating, ready asserted toward the granted requester
// RUN   | one Booth add/shift step per clock, WIDTH steps total
// DONE  | product presented, waiting for res_ready
module booth_seq_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_m,
  input  logic [WIDTH-1:0]   req0_r,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_m,
  input  logic [WIDTH-1:0]   req1_r,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_product,
  output logic               res_id,
  output logic               busy
);

  // One extra bit above the product so that negating the most negative M cannot overflow.
  localparam int PW = 2*WIDTH + 2;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [PW-1:0]      a_q, a_d;
  logic [PW-1:0]      s_q, s_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0] res_product_q, res_product_d;
  logic               res_id_q, res_id_d;
  logic               busy_q, busy_d;

  logic               grant;
  logic               accept;
  logic [WIDTH-1:0]   m_sel;
  logic [WIDTH-1:0]   r_sel;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     m_neg;
  logic [PW-1:0]      p_sum;
  logic [PW-1:0]      p_shr;

  // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else begin
      grant = ~last_grant_q;
    end
    m_sel  = grant ? req1_m : req0_m;
    r_sel  = grant ? req1_r : req0_r;
    m_ext  = {m_sel[WIDTH-1], m_sel};
    m_neg  = ~m_ext + (WIDTH+1)'(1);
    accept = (state_q == IDLE) && (grant ? req1_valid : req0_valid);
  end

  assign req0_ready = (state_q == IDLE) && (grant == 1'b0);
  assign req1_ready = (state_q == IDLE) && (grant == 1'b1);

  // Booth step: add A or S according to the recoded pair, then arithmetic shift right.
  always_comb begin
    unique case (p_q[1:0])
      2'b01:   p_sum = p_q + a_q;
      2'b10:   p_sum = p_q + s_q;
      default: p_sum = p_q;
    endcase
    p_shr = {p_sum[PW-1], p_sum[PW-1:1]};
  end

  // Next-state and next-output computation for the controller.
  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    a_d           = a_q;
    s_d           = s_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    res_valid_d   = res_valid_q;
    res_product_d = res_product_q;
    res_id_d      = res_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          p_d          = {{(WIDTH+1){1'b0}}, r_sel, 1'b0};
          a_d          = {m_ext, {(WIDTH+1){1'b0}}};
          s_d          = {m_neg, {(WIDTH+1){1'b0}}};
          cnt_d        = '0;
          res_id_d     = grant;
          last_grant_d = grant;
          state_d      = RUN;
`ifdef BOOTH_ZERO_BYPASS_EN
          // Zero operand: product is known to be zero, skip the Booth steps.
          // res_valid is raised by the DONE branch one edge later.
          if ((m_sel == '0) || (r_sel == '0)) begin
            p_d           = '0;
            res_product_d = '0;
            state_d       = DONE;
          end
`endif
        end
      end
      RUN: begin
        p_d   = p_shr;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d       = DONE;
          res_valid_d   = 1'b1;
          res_product_d = p_shr[2*WIDTH:1];
        end
      end
      DONE: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      p_q           <= '0;
      a_q           <= '0;
      s_q           <= '0;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_id_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      a_q           <= a_d;
      s_q           <= s_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_id_q      <= res_id_d;
      busy_q        <= busy_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign res_id      = res_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_booth_seq_arbiter.sv
// Scoreboard bench for booth_seq_arbiter (WIDTH=4): stimulus pushes expected
// {id, product} entries, a monitor pops and compares on each result handshake.
module tb_booth_seq_arbiter;

  localparam int WIDTH = 4;
`ifdef BOOTH_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = WIDTH;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_m = '0, req0_r = '0, req1_m = '0, req1_r = '0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_product;
  logic       res_id;
  logic       busy;

  booth_seq_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m), .req0_r(req0_r),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m), .req1_r(req1_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic id; logic [7:0] p;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every result handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", {23'd0, res_id, res_product}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_product", {24'd0, res_product}, {24'd0, e.p});
        chk("res_id", {31'd0, res_id}, {31'd0, e.id});
      end
    end
  end

  function automatic logic [7:0] model(input logic [3:0] m, input logic [3:0] r);
    logic signed [3:0] ms, rs;
    logic signed [7:0] pr;
    ms = m; rs = r;
    pr = ms * rs;
    return pr;
  endfunction

  // Present one request and hold it until accepted; acc_cyc is the cycle count after the accepting edge.
  task automatic drive(input int id, input logic [3:0] m, input logic [3:0] r,
                       input bit push, input logic [7:0] ep, output int acc_cyc);
    logic rdy;
    acc_cyc = -1;
    if (id == 0) begin req0_valid = 1'b1; req0_m = m; req0_r = r; end
    else         begin req1_valid = 1'b1; req1_m = m; req1_r = r; end
    for (int n = 0; n < 200; n++) begin
      #1;
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (rdy) begin
        if (push) q.push_back('{id[0], ep});
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 32'd0, 32'd1);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Count edges from acceptance to the first cycle with res_valid high.
  task automatic latency(input string name, input int acc, input int exp_lat);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (res_valid) begin
        chk(name, cyc - acc, exp_lat);
        return;
      end
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int a0, a1;
    #12;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_product", {24'd0, res_product}, 32'd0);
    chk("rst_res_id", {31'd0, res_id}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Both requesters compete from reset: grants must alternate 0,1,0,1.
    q.push_back('{1'b0, 8'h06});
    q.push_back('{1'b1, 8'hF4});
    q.push_back('{1'b0, 8'hFB});
    q.push_back('{1'b1, 8'h31});
    fork
      begin
        int t;
        drive(0, 4'd2, 4'd3, 1'b0, 8'h00, t);
        drive(0, 4'hF, 4'd5, 1'b0, 8'h00, t);
      end
      begin
        int t;
        drive(1, 4'hD, 4'd4, 1'b0, 8'h00, t);
        drive(1, 4'd7, 4'd7, 1'b0, 8'h00, t);
      end
    join

    // 3 * -2 with latency check.
    drive(0, 4'd3, 4'hE, 1'b1, 8'hFA, a0);
    latency("latency_3x-2", a0, WIDTH);
    // -8 * -8 on requester 1.
    drive(1, 4'h8, 4'h8, 1'b1, 8'h40, a1);
    latency("latency_-8x-8", a1, WIDTH);
    // Zero operands.
    drive(0, 4'd0, 4'd5, 1'b1, 8'h00, a0);
    latency("latency_zero_m", a0, ZERO_LAT);
    drive(1, 4'd6, 4'd0, 1'b1, 8'h00, a1);
    latency("latency_zero_r", a1, ZERO_LAT);

    // Back-pressure: result must hold while res_ready is low, req1 waits.
    @(posedge clk); #1;
    res_ready = 1'b0;
    drive(0, 4'd5, 4'hD, 1'b1, 8'hF1, a0);
    fork
      begin
        int t;
        drive(1, 4'd1, 4'd1, 1'b1, 8'h01, t);
      end
    join_none
    latency("latency_stall", a0, WIDTH);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_product", {24'd0, res_product}, 32'h0000_00F1);
      chk("stall_id", {31'd0, res_id}, 32'd0);
      chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", {31'd0, res_valid}, 32'd0);
    chk("post_hs_req1_ready", {31'd0, req1_ready}, 32'd1);
    wait fork;

    // Reset pulsed after two Booth steps: aborted op must never produce a result.
    drive(0, 4'd3, 4'd3, 1'b0, 8'h00, a0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_product", {24'd0, res_product}, 32'd0);
    chk("abort_id", {31'd0, res_id}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b1; req0_m = 4'd4; req0_r = 4'd4;
    req1_valid = 1'b1; req1_m = 4'd2; req1_r = 4'hF;
    #1;
    chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    fork
      begin
        int t;
        drive(0, 4'd4, 4'd4, 1'b1, 8'h10, t);
      end
      begin
        int t;
        drive(1, 4'd2, 4'hF, 1'b1, 8'hFE, t);
      end
    join

    // Exhaustive sweep on requester 0 against the signed reference.
    for (int m = 0; m < 16; m++) begin
      for (int r = 0; r < 16; r++) begin
        drive(0, m[3:0], r[3:0], 1'b1, model(m[3:0], r[3:0]), a0);
      end
    end

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !res_valid) break;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
